// File: rtl/wb_arbiter2.sv
// Two-source round-robin arbiter feeding a one-entry registered output stage
// with valid/ready handshake and per-source acceptance counters.
module wb_arbiter2 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    output logic             ack1,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sel,
    input  logic             out_ready,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic last_sel;
    logic load_en;
    logic both_req;
    logic sel;
    logic grant;

    // Arbitration depends only on req, out_ready, state and last_sel; data
    // never reaches ack.
    always_comb begin
        load_en  = (state == S_EMPTY) || out_ready;
        both_req = req0 && req1;
        sel      = both_req ? ~last_sel : req1;
        grant    = load_en && (req0 || req1) && !rst;
    end

    assign ack0      = grant && !sel;
    assign ack1      = grant && sel;
    assign out_valid = (state == S_FULL);

    // NOTE: every signal written in a combinational block gets a default
    // first, otherwise an unassigned path infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            S_EMPTY: begin
                if (grant) state_nxt = S_FULL;
            end
            S_FULL: begin
                if (grant)          state_nxt = S_FULL;
                else if (out_ready) state_nxt = S_EMPTY;
            end
            default: state_nxt = S_EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_EMPTY;
        else     state <= state_nxt;
    end

    // last_sel resets to 1 so that source 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
            out_sel  <= 1'b0;
            last_sel <= 1'b1;
        end else if (grant) begin
            out_data <= sel ? data1 : data0;
            out_sel  <= sel;
            last_sel <= sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (ack0) cnt0 <= cnt0 + CNT_W'(1);
            if (ack1) cnt1 <= cnt1 + CNT_W'(1);
        end
    end

endmodule
